// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hz_state_t   : sequencer states
//   REG_ZERO     : architectural zero register (never a real producer)
//   stage_ctrl_t : stall/flush enables for the pipeline registers
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 3;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_STALL = 2'd1,
    MC_WAIT  = 2'd2,
    REDIRECT = 2'd3
  } hz_state_t;

  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic flushD;
    logic flushE;
    logic flushM;
  } stage_ctrl_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side signal bundle of the hazard controller.
//   slave  : the controller (reads pipeline status, drives stall/flush)
//   master : the pipeline / environment
interface hazard_controller_if #(
  parameter int unsigned STALL_CNT_W = 32
) ();
  logic [4:0] rs1D;
  logic [4:0] rs2D;
  logic       use_rs1D;
  logic       use_rs2D;
  logic [4:0] rdE;
  logic [4:0] rdM;
  logic       MemReadE;
  logic       MemReadM;
  logic       RegWriteE;
  logic       RegWriteM;
  logic       mc_opE;
  logic       mc_done;
  logic       pc_redirectE;

  logic       mc_start;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       flushD;
  logic       flushE;
  logic       flushM;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport slave (
    input  rs1D, rs2D, use_rs1D, use_rs2D, rdE, rdM,
           MemReadE, MemReadM, RegWriteE, RegWriteM,
           mc_opE, mc_done, pc_redirectE,
    output mc_start, stallF, stallD, stallE, flushD, flushE, flushM,
           stall_cycles
  );

  modport master (
    output rs1D, rs2D, use_rs1D, use_rs2D, rdE, rdM,
           MemReadE, MemReadM, RegWriteE, RegWriteM,
           mc_opE, mc_done, pc_redirectE,
    input  mc_start, stallF, stallD, stallE, flushD, flushE, flushM,
           stall_cycles
  );
endinterface

// File: rtl/hazard_controller_loaduse_detect.sv
// Combinational load-use detection against the E and M stage loads.
//   inputs : decode sources/use flags, E/M destination, load and write flags
//   outputs: hitE (load in E feeds D), hitM (load in M feeds D)
module loaduse_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic             use_rs1D,
  input  logic             use_rs2D,
  input  logic [REG_W-1:0] rdE,
  input  logic [REG_W-1:0] rdM,
  input  logic             MemReadE,
  input  logic             MemReadM,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  output logic             hitE,
  output logic             hitM
);

  always_comb begin
    hitE = MemReadE & RegWriteE & (rdE != REG_ZERO) &
           ((use_rs1D & (rdE == rs1D)) | (use_rs2D & (rdE == rs2D)));
    hitM = MemReadM & RegWriteM & (rdM != REG_ZERO) &
           ((use_rs1D & (rdM == rs1D)) | (use_rs2D & (rdM == rs2D)));
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 6-stage pipeline: load-use stalls,
// multicycle E-stage ops (start/done handshake) and E-stage redirects.
//   clk, rst : clock, asynchronous active-high reset
//   hz       : pipeline status in, stall/flush/mc_start and stall counter out
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REDIRECT_BUBBLES = 2,
  parameter int unsigned LDUSE_E_STALL    = 2,
  parameter int unsigned STALL_CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  hazard_controller_if.slave  hz
);

  // Counter reload values; only used when the corresponding length exceeds 1.
  localparam logic [CNT_W-1:0] REDIR_RELOAD =
    CNT_W'((REDIRECT_BUBBLES > 1) ? REDIRECT_BUBBLES - 2 : 0);
  localparam logic [CNT_W-1:0] LD_RELOAD =
    CNT_W'((LDUSE_E_STALL > 1) ? LDUSE_E_STALL - 2 : 0);

  hz_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q;
  stage_ctrl_t            ctrl;
  logic                   mc_start_c;
  logic                   hitE, hitM;

  loaduse_detect u_loaduse_detect (
    .rs1D      (hz.rs1D),
    .rs2D      (hz.rs2D),
    .use_rs1D  (hz.use_rs1D),
    .use_rs2D  (hz.use_rs2D),
    .rdE       (hz.rdE),
    .rdM       (hz.rdM),
    .MemReadE  (hz.MemReadE),
    .MemReadM  (hz.MemReadM),
    .RegWriteE (hz.RegWriteE),
    .RegWriteM (hz.RegWriteM),
    .hitE      (hitE),
    .hitM      (hitM)
  );

  // State and bubble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stage controls.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl       = '0;
    mc_start_c = 1'b0;
    case (state_q)
      IDLE: begin
        // A redirect kills whatever sits in E, including a multicycle op.
        if (hz.pc_redirectE) begin
          ctrl.flushD = 1'b1;
          ctrl.flushE = 1'b1;
          if (REDIRECT_BUBBLES > 1) begin
            state_d = REDIRECT;
            cnt_d   = REDIR_RELOAD;
          end
        end else if (hz.mc_opE) begin
          mc_start_c  = 1'b1;
          ctrl.stallF = 1'b1;
          ctrl.stallD = 1'b1;
          ctrl.stallE = 1'b1;
          ctrl.flushM = 1'b1;
          state_d     = MC_WAIT;
        end else if (hitE) begin
          ctrl.stallF = 1'b1;
          ctrl.stallD = 1'b1;
          ctrl.flushE = 1'b1;
          if (LDUSE_E_STALL > 1) begin
            state_d = LD_STALL;
            cnt_d   = LD_RELOAD;
          end
        end else if (hitM) begin
          ctrl.stallF = 1'b1;
          ctrl.stallD = 1'b1;
          ctrl.flushE = 1'b1;
        end
      end
      LD_STALL: begin
        ctrl.stallF = 1'b1;
        ctrl.stallD = 1'b1;
        ctrl.flushE = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      MC_WAIT: begin
        // Release in the done cycle so the result moves to M on the next edge.
        if (hz.mc_done) begin
          state_d = IDLE;
        end else begin
          ctrl.stallF = 1'b1;
          ctrl.stallD = 1'b1;
          ctrl.stallE = 1'b1;
          ctrl.flushM = 1'b1;
        end
      end
      REDIRECT: begin
        ctrl.flushD = 1'b1;
        if (hz.pc_redirectE) begin
          ctrl.flushE = 1'b1;
          cnt_d       = REDIR_RELOAD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (ctrl.stallF && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + STALL_CNT_W'(1);
    end
  end

  // Inputs still reach the decode logic during reset, so gate every control.
  assign hz.mc_start     = mc_start_c  & ~rst;
  assign hz.stallF       = ctrl.stallF & ~rst;
  assign hz.stallD       = ctrl.stallD & ~rst;
  assign hz.stallE       = ctrl.stallE & ~rst;
  assign hz.flushD       = ctrl.flushD & ~rst;
  assign hz.flushE       = ctrl.flushE & ~rst;
  assign hz.flushM       = ctrl.flushM & ~rst;
  assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios followed by
// random traffic, all compared against a remaining-cycles reference model.
module tb_hazard_controller;

  localparam int unsigned RB = 2;
  localparam int unsigned LD = 2;
  localparam int unsigned CW = 6;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  // Reference model: cycles left in each kind of hold, plus the stall count.
  int   m_ld_rem;
  int   m_redir_rem;
  bit   m_mc_busy;
  int   m_cnt;

  hazard_controller_if #(.STALL_CNT_W(CW)) hif ();

  hazard_controller #(
    .REDIRECT_BUBBLES (RB),
    .LDUSE_E_STALL    (LD),
    .STALL_CNT_W      (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ld_rem    = 0;
    m_redir_rem = 0;
    m_mc_busy   = 1'b0;
    m_cnt       = 0;
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance a clock.
  task automatic step(input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2,
                      input logic [4:0] re, input logic [4:0] rm,
                      input logic mre, input logic mrm,
                      input logic rwe, input logic rwm,
                      input logic mc, input logic done, input logic redir);
    bit hit_e, hit_m;
    bit e_start, e_sf, e_sd, e_se, e_fd, e_fe, e_fm;
    hif.rs1D = r1; hif.rs2D = r2; hif.use_rs1D = u1; hif.use_rs2D = u2;
    hif.rdE = re; hif.rdM = rm; hif.MemReadE = mre; hif.MemReadM = mrm;
    hif.RegWriteE = rwe; hif.RegWriteM = rwm;
    hif.mc_opE = mc; hif.mc_done = done; hif.pc_redirectE = redir;
    #1;
    chk("stall_cycles", 32'(hif.stall_cycles), 32'(m_cnt));

    hit_e = mre && rwe && (re != 0) && ((u1 && re == r1) || (u2 && re == r2));
    hit_m = mrm && rwm && (rm != 0) && ((u1 && rm == r1) || (u2 && rm == r2));
    {e_start, e_sf, e_sd, e_se, e_fd, e_fe, e_fm} = '0;

    if (m_mc_busy) begin
      if (done) m_mc_busy = 1'b0;
      else {e_sf, e_sd, e_se, e_fm} = 4'b1111;
    end else if (m_ld_rem > 0) begin
      {e_sf, e_sd, e_fe} = 3'b111;
      m_ld_rem--;
    end else if (m_redir_rem > 0) begin
      e_fd = 1'b1;
      if (redir) begin
        e_fe = 1'b1;
        m_redir_rem = RB - 1;
      end else begin
        m_redir_rem--;
      end
    end else if (redir) begin
      {e_fd, e_fe} = 2'b11;
      m_redir_rem = RB - 1;
    end else if (mc) begin
      {e_start, e_sf, e_sd, e_se, e_fm} = 5'b11111;
      m_mc_busy = 1'b1;
    end else if (hit_e) begin
      {e_sf, e_sd, e_fe} = 3'b111;
      m_ld_rem = LD - 1;
    end else if (hit_m) begin
      {e_sf, e_sd, e_fe} = 3'b111;
    end

    chk("mc_start", 32'(hif.mc_start), 32'(e_start));
    chk("stallF",   32'(hif.stallF),   32'(e_sf));
    chk("stallD",   32'(hif.stallD),   32'(e_sd));
    chk("stallE",   32'(hif.stallE),   32'(e_se));
    chk("flushD",   32'(hif.flushD),   32'(e_fd));
    chk("flushE",   32'(hif.flushE),   32'(e_fe));
    chk("flushM",   32'(hif.flushM),   32'(e_fm));

    if (e_sf && m_cnt != int'(CNT_MAX)) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_low(input string tag);
    chk({tag, "_mc_start"}, 32'(hif.mc_start), 32'd0);
    chk({tag, "_stallF"},   32'(hif.stallF),   32'd0);
    chk({tag, "_stallD"},   32'(hif.stallD),   32'd0);
    chk({tag, "_stallE"},   32'(hif.stallE),   32'd0);
    chk({tag, "_flushD"},   32'(hif.flushD),   32'd0);
    chk({tag, "_flushE"},   32'(hif.flushE),   32'd0);
    chk({tag, "_flushM"},   32'(hif.flushM),   32'd0);
  endtask

  initial begin
    logic [4:0] r1, r2, re, rm;
    logic u1, u2, mre, mrm, rwe, rwm, mc, done, redir;
    tests  = 0;
    failed = 0;
    model_reset();

    // Reset with a multicycle op and a load-use visible: nothing may assert.
    rst = 1'b1;
    hif.rs1D = 5'd5; hif.rs2D = 5'd0; hif.use_rs1D = 1'b1; hif.use_rs2D = 1'b0;
    hif.rdE = 5'd5; hif.rdM = 5'd0; hif.MemReadE = 1'b1; hif.MemReadM = 1'b0;
    hif.RegWriteE = 1'b1; hif.RegWriteM = 1'b0;
    hif.mc_opE = 1'b1; hif.mc_done = 1'b0; hif.pc_redirectE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_low("reset");
    chk("reset_stall_cycles", 32'(hif.stall_cycles), 32'd0);
    rst = 1'b0;

    // lw x5 in E, add x6,x5,x1 in D: two stall cycles.
    repeat (2) step(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_step();
    chk("lduse_e_count", 32'(hif.stall_cycles), 32'd2);

    // lw x5 in M, D reads x5 via rs2: one stall; with rdM=0 nothing.
    step(5'd1, 5'd5, 1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_step();

    // Multicycle op, done five cycles after start.
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_step();

    // Redirect with a load-use hit and a multicycle op also present.
    step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_step();

    // Back-to-back redirects extend the flushD window.
    repeat (2) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) idle_step();

    // Long multicycle wait drives the counter into saturation.
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (60) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(5'd1, 5'd5, 1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_step();
    chk("saturated", 32'(hif.stall_cycles), 32'(CNT_MAX));

    // Reset in the third MC_WAIT cycle: outputs drop asynchronously.
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_all_low("midrst");
    chk("midrst_stall_cycles", 32'(hif.stall_cycles), 32'd0);
    hif.mc_opE = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    idle_step();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_step();

    // Random traffic over a small register range so hits are frequent.
    for (int i = 0; i < 500; i++) begin
      r1    = 5'($urandom_range(0, 3));
      r2    = 5'($urandom_range(0, 3));
      re    = 5'($urandom_range(0, 3));
      rm    = 5'($urandom_range(0, 3));
      u1    = 1'($urandom_range(0, 1));
      u2    = 1'($urandom_range(0, 1));
      mre   = 1'($urandom_range(0, 1));
      mrm   = 1'($urandom_range(0, 1));
      rwe   = 1'($urandom_range(0, 3) != 0);
      rwm   = 1'($urandom_range(0, 3) != 0);
      mc    = 1'($urandom_range(0, 7) == 0);
      redir = 1'($urandom_range(0, 7) == 0);
      done  = m_mc_busy ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      step(r1, r2, u1, u2, re, rm, mre, mrm, rwe, rwm, mc, done, redir);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
